// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the RX FIFO write port between the UART receiver and a local byte source (FIFO_ARB_FIXED_PRIO_EN: requester 0 always wins ties)
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  input  logic                  Req0Valid,
  output logic                  Req0Drop,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  input  logic                  Req1Valid,
  output logic                  Req1Ready,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  WriteEnable,
  input  logic                  Full,
  input  logic                  DropClear,
  output logic [7:0]            DropCount
);
  logic                  hold0_valid, hold1_valid, last_grant, tie_to0;
  logic                  grant0, grant1, accept0, drop, xfer1;
  logic [DATA_WIDTH-1:0] hold0_data, hold1_data;
`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign tie_to0 = 1'b1;
`else
  assign tie_to0 = last_grant;
`endif
  // grant a hold only while the FIFO has room; Req1Ready comes straight from the hold flag so Full never reaches it
  always_comb begin
    grant0      = !Full && hold0_valid && (!hold1_valid || tie_to0);
    grant1      = !Full && hold1_valid && (!hold0_valid || !tie_to0);
    accept0     = Req0Valid && (!hold0_valid || grant0);
    drop        = Req0Valid && !accept0;
    Req1Ready   = !hold1_valid;
    xfer1       = Req1Valid && !hold1_valid;
    WriteEnable = grant0 || grant1;
    DataOut     = grant1 ? hold1_data : hold0_data;
  end
  // hold buffers and round-robin history; a granted hold 0 can be refilled on the same edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold0_valid <= 1'b0;
      hold1_valid <= 1'b0;
      hold0_data  <= '0;
      hold1_data  <= '0;
      last_grant  <= 1'b1;
    end else begin
      hold0_valid <= accept0 ? 1'b1 : grant0 ? 1'b0 : hold0_valid;
      hold0_data  <= accept0 ? Req0Data : hold0_data;
      hold1_valid <= xfer1 ? 1'b1 : grant1 ? 1'b0 : hold1_valid;
      hold1_data  <= xfer1 ? Req1Data : hold1_data;
      last_grant  <= grant0 ? 1'b0 : grant1 ? 1'b1 : last_grant;
    end
  end
  // drop pulse and saturating drop counter; a clear coinciding with a drop leaves a count of one
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Req0Drop  <= 1'b0;
      DropCount <= 8'd0;
    end else begin
      Req0Drop  <= drop;
      DropCount <= DropClear ? {7'd0, drop} : (drop && DropCount != 8'hff) ? DropCount + 8'd1 : DropCount;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed test-plan checks plus randomized traffic against a slot-based reference model
module tb_fifo_write_arbiter;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Req0Data = 8'd0, Req1Data = 8'd0;
  logic       Req0Valid = 1'b0, Req1Valid = 1'b0, Full = 1'b0, DropClear = 1'b0;
  logic [7:0] DataOut, DropCount;
  logic       Req0Drop, Req1Ready, WriteEnable;
  int         checks = 0, failures = 0;
  bit         run = 1'b0;
  bit         mv [2];
  byte unsigned md [2];
  int         mlast = 1, mcnt = 0;
  bit         mdrop = 1'b0, mxfer1 = 1'b0;
  fifo_write_arbiter #(.DATA_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0Data(Req0Data), .Req0Valid(Req0Valid), .Req0Drop(Req0Drop),
    .Req1Data(Req1Data), .Req1Valid(Req1Valid), .Req1Ready(Req1Ready),
    .DataOut(DataOut), .WriteEnable(WriteEnable), .Full(Full),
    .DropClear(DropClear), .DropCount(DropCount)
  );
  always #5 Clk = ~Clk;
  // which slot the FIFO takes this cycle: -1 none, else slot index
  function automatic int winner();
    if (Full) return -1;
    if (mv[0] && mv[1]) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (mlast == 0) ? 1 : 0;
`endif
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask
  // reference model: two slots, served-last memory, drop tally
  initial begin
    int w;
    bit rdy, dr;
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
        mv[0] = 0; mv[1] = 0; md[0] = 0; md[1] = 0;
        mlast = 1; mcnt = 0; mdrop = 0; mxfer1 = 0;
      end else begin
        w = winner();
        rdy = !mv[1];
        dr = 0;
        if (w >= 0) begin
          mv[w] = 0;
          mlast = w;
        end
        if (Req0Valid) begin
          if (!mv[0]) begin
            mv[0] = 1;
            md[0] = Req0Data;
          end else dr = 1;
        end
        mxfer1 = Req1Valid && rdy;
        if (mxfer1) begin
          mv[1] = 1;
          md[1] = Req1Data;
        end
        if (DropClear) mcnt = dr ? 1 : 0;
        else if (dr && mcnt < 255) mcnt++;
        mdrop = dr;
      end
    end
  end
  // per-cycle comparison of every output against the model
  initial begin
    int w;
    forever begin
      @(negedge Clk);
      if (run) begin
        w = winner();
        chk("we", 32'(WriteEnable), 32'(w >= 0));
        chk("dout", 32'(DataOut), 32'((w == 1) ? md[1] : md[0]));
        chk("ready", 32'(Req1Ready), 32'(!mv[1]));
        chk("drop", 32'(Req0Drop), 32'(mdrop));
        chk("count", 32'(DropCount), 32'(mcnt));
      end
    end
  end
  initial begin
    int pct;
    logic [7:0] first, second;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    first = 8'h10; second = 8'h20;
`else
    first = 8'h20; second = 8'h10;
`endif
    repeat (3) tick();
    #1;
    chk("rst_we", 32'(WriteEnable), 0);
    chk("rst_dout", 32'(DataOut), 0);
    chk("rst_ready", 32'(Req1Ready), 1);
    chk("rst_drop", 32'(Req0Drop), 0);
    chk("rst_count", 32'(DropCount), 0);
    Reset = 1'b1;
    run = 1'b1;
    tick();
    Req0Valid = 1; Req0Data = 8'h41;
    tick();
    Req0Valid = 0;
    #1;
    chk("single_we", 32'(WriteEnable), 1);
    chk("single_dout", 32'(DataOut), 32'h41);
    chk("single_ready", 32'(Req1Ready), 1);
    tick();
    #1;
    chk("single_once", 32'(WriteEnable), 0);
    chk("single_ready2", 32'(Req1Ready), 1);
    for (int k = 0; k < 2; k++) begin
      Req0Valid = 1; Req0Data = 8'h10; Req1Valid = 1; Req1Data = 8'h20;
      tick();
      Req0Valid = 0; Req1Valid = 0;
      #1;
      chk("tie_first", 32'(DataOut), 32'(first));
      chk("tie_first_we", 32'(WriteEnable), 1);
      tick();
      #1;
      chk("tie_second", 32'(DataOut), 32'(second));
      chk("tie_second_we", 32'(WriteEnable), 1);
      tick();
      #1;
      chk("tie_idle", 32'(WriteEnable), 0);
    end
    Full = 1; Req0Valid = 1; Req0Data = 8'h01;
    tick();
    Req0Data = 8'h02;
    #1 chk("full_nodrop", 32'(Req0Drop), 0);
    tick();
    Req0Data = 8'h03;
    #1 chk("full_drop1", 32'(Req0Drop), 1);
    tick();
    Req0Valid = 0;
    #1;
    chk("full_drop2", 32'(Req0Drop), 1);
    chk("full_count", 32'(DropCount), 2);
    chk("full_nowe", 32'(WriteEnable), 0);
    tick();
    #1;
    chk("full_pulse_end", 32'(Req0Drop), 0);
    Full = 0;
    #1;
    chk("release_we", 32'(WriteEnable), 1);
    chk("release_dout", 32'(DataOut), 32'h01);
    tick();
    #1 chk("release_once", 32'(WriteEnable), 0);
    Req0Valid = 1; Req0Data = 8'h55;
    tick();
    Req0Data = 8'hAA;
    #1 chk("reacc_55", 32'(DataOut), 32'h55);
    tick();
    Req0Valid = 0;
    #1;
    chk("reacc_aa", 32'(DataOut), 32'hAA);
    chk("reacc_aa_we", 32'(WriteEnable), 1);
    chk("reacc_nodrop", 32'(Req0Drop), 0);
    tick();
    #1;
    chk("reacc_idle", 32'(WriteEnable), 0);
    chk("reacc_count", 32'(DropCount), 2);
    Full = 1; Req0Valid = 1;
    repeat (300) tick();
    #1 chk("sat_count", 32'(DropCount), 255);
    DropClear = 1;
    tick();
    DropClear = 0; Req0Valid = 0;
    #1 chk("clear_with_drop", 32'(DropCount), 1);
    DropClear = 1;
    tick();
    DropClear = 0;
    #1 chk("clear_plain", 32'(DropCount), 0);
    Req1Valid = 1; Req1Data = 8'h77;
    tick();
    Req1Valid = 0; Full = 0;
    #1;
    chk("stall_ready", 32'(Req1Ready), 0);
    chk("stall_we_open", 32'(WriteEnable), 1);
    Reset = 0;
    #1;
    chk("arst_we", 32'(WriteEnable), 0);
    chk("arst_ready", 32'(Req1Ready), 1);
    chk("arst_dout", 32'(DataOut), 0);
    tick();
    tick();
    Reset = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_we", 32'(WriteEnable), 0);
      chk("post_rst_ready", 32'(Req1Ready), 1);
      tick();
    end
    for (int i = 0; i < 4000; i++) begin
      pct = (i / 500) % 4 == 0 ? 0 : (i / 500) % 4 == 1 ? 20 : (i / 500) % 4 == 2 ? 60 : 95;
      Req0Valid = ($urandom_range(0, 9) < 4);
      Req0Data = 8'($urandom);
      if (mxfer1) Req1Valid = 0;
      if (!Req1Valid && $urandom_range(0, 1) == 1) begin
        Req1Valid = 1;
        Req1Data = 8'($urandom);
      end
      Full = ($urandom_range(0, 99) < pct);
      DropClear = ($urandom_range(0, 49) == 0);
      tick();
    end
    Req0Valid = 0; Req1Valid = 0; Full = 0; DropClear = 0;
    tick();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
